cpu_run_controller: RTL and testbench

//  Synthesizable run/reset sequencer and result monitor for the multicycle CPU top level.

---
 rtl/cpu_run_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_cpu_run_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Run/reset sequencer and result monitor for the multicycle CPU top level.
//   - Holds the core in reset for RESET_CYCLES cycles, then releases it.
//   - While running, counts cycles and logs every change of alu_output into a
//     circular trace buffer of DEPTH entries (oldest entry overwritten on wrap).
//   - Declares completion after STABLE_CYCLES consecutive unchanged samples.
//   - Optional cycle limit: define RUN_CTRL_TIMEOUT_EN to end a run after
//     MAX_CYCLES counted cycles with timeout=1. Without the macro, timeout is
//     constant 0 and a run ends only by stability or reset.
module cpu_run_controller #(
  parameter int WIDTH         = 32,
  parameter int RESET_CYCLES  = 5,
  parameter int DEPTH         = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_CYCLES    = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     restart,
  input  logic [WIDTH-1:0]         alu_output,
  output logic                     cpu_reset,
  output logic                     running,
  output logic                     done,
  output logic                     timeout,
  output logic [31:0]              cycle_count,
  output logic [$clog2(DEPTH):0]   trace_count,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_CNT   = CW'(DEPTH);
  localparam logic [31:0]   CYCLE_LIMIT = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]   CYCLE_MAX   = 32'hFFFF_FFFF;

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [HW-1:0]     hold_cnt_r;
  logic [SW-1:0]     stable_cnt_r;
  logic [31:0]       cycle_count_r;
  logic [CW-1:0]     trace_count_r;
  logic [AW-1:0]     wr_ptr_r;
  logic              have_last_r;
  logic [WIDTH-1:0]  last_r;
  logic              cpu_reset_r;
  logic              running_r;
  logic              done_r;
  logic              timeout_r;
  logic [WIDTH-1:0]  rd_data_r;
  logic [WIDTH-1:0]  trace_mem_r [DEPTH];

  logic              sample_new_s;
  logic              stable_hit_s;
  logic              limit_hit_s;
  logic              trace_full_s;
  logic              trace_wr_en_s;
  logic [31:0]       cycle_next_s;
  logic [AW-1:0]     rd_addr_s;
  logic              rd_hit_s;

  // Per-cycle decisions shared by the sequencer, trace write and read port.
  always_comb begin
    sample_new_s  = 1'b0;
    stable_hit_s  = 1'b0;
    limit_hit_s   = 1'b0;
    trace_full_s  = 1'b0;
    trace_wr_en_s = 1'b0;
    cycle_next_s  = cycle_count_r;
    rd_addr_s     = wr_ptr_r;
    rd_hit_s      = 1'b0;

    // A sample is "new" before the first capture or whenever the bus moved.
    if (!have_last_r) begin
      sample_new_s = 1'b1;
    end else begin
      sample_new_s = (alu_output != last_r);
    end

    if (!sample_new_s && (stable_cnt_r == STABLE_LAST)) begin
      stable_hit_s = 1'b1;
    end else begin
      stable_hit_s = 1'b0;
    end

    if (cycle_count_r == CYCLE_MAX) begin
      cycle_next_s = cycle_count_r;
    end else begin
      cycle_next_s = cycle_count_r + 32'd1;
    end

    limit_hit_s   = TIMEOUT_EN && (cycle_count_r == CYCLE_LIMIT);
    trace_full_s  = (trace_count_r == DEPTH_CNT);
    trace_wr_en_s = !reset && (state_r == ST_RUN) && sample_new_s;

    // Oldest valid entry sits trace_count slots behind the write pointer.
    rd_addr_s = wr_ptr_r - trace_count_r[AW-1:0] + rd_idx;
    rd_hit_s  = ({1'b0, rd_idx} < trace_count_r);
  end

  // Run sequencer: HOLD -> RUN -> DONE, with counters and registered status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_HOLD;
      hold_cnt_r    <= {HW{1'b0}};
      stable_cnt_r  <= {SW{1'b0}};
      cycle_count_r <= 32'd0;
      trace_count_r <= {CW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      have_last_r   <= 1'b0;
      last_r        <= {WIDTH{1'b0}};
      cpu_reset_r   <= 1'b1;
      running_r     <= 1'b0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r     <= ST_RUN;
            cpu_reset_r <= 1'b0;
            running_r   <= 1'b1;
          end else begin
            hold_cnt_r  <= hold_cnt_r + {{(HW-1){1'b0}}, 1'b1};
            cpu_reset_r <= 1'b1;
          end
        end

        ST_RUN: begin
          cycle_count_r <= cycle_next_s;
          if (sample_new_s) begin
            wr_ptr_r     <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            last_r       <= alu_output;
            have_last_r  <= 1'b1;
            stable_cnt_r <= {SW{1'b0}};
            if (!trace_full_s) begin
              trace_count_r <= trace_count_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
              trace_count_r <= trace_count_r;
            end
          end else if (!stable_hit_s) begin
            stable_cnt_r <= stable_cnt_r + {{(SW-1){1'b0}}, 1'b1};
          end else begin
            stable_cnt_r <= stable_cnt_r;
          end

          // Stability wins over the cycle limit when both fire together.
          if (stable_hit_s) begin
            state_r   <= ST_DONE;
            running_r <= 1'b0;
            done_r    <= 1'b1;
            timeout_r <= 1'b0;
          end else if (limit_hit_s) begin
            state_r   <= ST_DONE;
            running_r <= 1'b0;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            state_r   <= ST_RUN;
          end
        end

        ST_DONE: begin
          if (restart) begin
            state_r       <= ST_HOLD;
            hold_cnt_r    <= {HW{1'b0}};
            stable_cnt_r  <= {SW{1'b0}};
            cycle_count_r <= 32'd0;
            trace_count_r <= {CW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            have_last_r   <= 1'b0;
            cpu_reset_r   <= 1'b1;
            running_r     <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
          end else begin
            state_r       <= ST_DONE;
          end
        end

        default: begin
          state_r     <= ST_HOLD;
          hold_cnt_r  <= {HW{1'b0}};
          cpu_reset_r <= 1'b1;
          running_r   <= 1'b0;
          done_r      <= 1'b0;
          timeout_r   <= 1'b0;
        end
      endcase
    end
  end

  // Trace storage: capture each changed RUN sample at the write pointer.
  always_ff @(posedge clock) begin
    if (trace_wr_en_s) begin
      trace_mem_r[wr_ptr_r] <= alu_output;
    end
  end

  // Registered trace read port; indices beyond the valid entries read as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_hit_s) begin
      rd_data_r <= trace_mem_r[rd_addr_s];
    end else begin
      rd_data_r <= {WIDTH{1'b0}};
    end
  end

  assign cpu_reset   = cpu_reset_r;
  assign running     = running_r;
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign cycle_count = cycle_count_r;
  assign trace_count = trace_count_r;
  assign rd_data     = rd_data_r;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller
//   Directed scenarios plus randomized traffic for cpu_run_controller, checked
//   every cycle against a queue-based reference model of the run controller.
//   Honours RUN_CTRL_TIMEOUT_EN when expecting the cycle-limit behaviour.
module tb_cpu_run_controller;

  localparam int W  = 32;
  localparam int RC = 5;
  localparam int D  = 16;
  localparam int SC = 4;
  localparam int MC = 24;

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         restart = 1'b0;
  logic [W-1:0] alu_output = '0;
  logic         cpu_reset;
  logic         running;
  logic         done;
  logic         timeout;
  logic [31:0]  cycle_count;
  logic [4:0]   trace_count;
  logic [3:0]   rd_idx = '0;
  logic [W-1:0] rd_data;

  cpu_run_controller #(
    .WIDTH(W), .RESET_CYCLES(RC), .DEPTH(D), .STABLE_CYCLES(SC), .MAX_CYCLES(MC)
  ) dut (
    .clock(clock), .reset(reset), .restart(restart), .alu_output(alu_output),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .trace_count(trace_count),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0=hold, 1=run, 2=done; trace kept oldest-first.
  int           m_phase = 0;
  int           m_hold = 0;
  longint       m_cycles = 0;
  logic [W-1:0] m_trace [$];
  bit           m_have = 1'b0;
  logic [W-1:0] m_last = '0;
  int           m_repeats = 0;
  bit           m_timeout = 1'b0;
  logic [W-1:0] m_rd = '0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_hold = 0; m_cycles = 0; m_trace.delete();
    m_have = 1'b0; m_repeats = 0; m_timeout = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit rs, input logic [W-1:0] val, input int idx);
    m_rd = (idx < m_trace.size()) ? m_trace[idx] : '0;
    if (rst) begin
      model_clear();
      m_rd = '0;
    end else begin
      case (m_phase)
        0: begin
          m_hold++;
          if (m_hold == RC) m_phase = 1;
        end
        1: begin
          if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
          if (!m_have || val != m_last) begin
            m_trace.push_back(val);
            if (m_trace.size() > D) void'(m_trace.pop_front());
            m_last = val; m_have = 1'b1; m_repeats = 0;
          end else begin
            m_repeats++;
          end
          if (m_repeats == SC) begin
            m_phase = 2; m_timeout = 1'b0;
          end else if (TO_EN && m_cycles == MC) begin
            m_phase = 2; m_timeout = 1'b1;
          end
        end
        2: if (rs) model_clear();
        default: model_clear();
      endcase
    end
  endtask

  task automatic compare_all();
    check_value("cpu_reset",   cpu_reset,   (m_phase == 0));
    check_value("running",     running,     (m_phase == 1));
    check_value("done",        done,        (m_phase == 2));
    check_value("timeout",     timeout,     m_timeout);
    check_value("cycle_count", cycle_count, m_cycles);
    check_value("trace_count", trace_count, m_trace.size());
    check_value("rd_data",     rd_data,     m_rd);
  endtask

  // One clock: drive after the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic tick(input bit rst, input bit rs, input logic [W-1:0] val, input int idx);
    reset = rst; restart = rs; alu_output = val; rd_idx = 4'(idx);
    @(posedge clock);
    model_step(rst, rs, val, idx);
    @(negedge clock);
    compare_all();
  endtask

  task automatic hold_phase(input string tag, input logic [W-1:0] val);
    int n;
    n = 0;
    while (cpu_reset && n < 20) begin
      tick(1'b0, 1'b0, val, 0);
      n++;
    end
    check_value(tag, n, RC);
  endtask

  task automatic run_to_done(input string tag, input logic [W-1:0] val);
    int n;
    n = 0;
    while (!done && n < 60) begin
      tick(1'b0, 1'b0, val, 0);
      n++;
    end
    check_value(tag, done, 1'b1);
  endtask

  int           n_run;
  bit           r_rst;
  bit           r_rs;
  logic [W-1:0] r_val;
  logic [W-1:0] seq2 [7];

  initial begin
    // 1: reset, then constant 0 until done.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, '0, 0);
    hold_phase("t1_hold_len", '0);
    n_run = 0;
    while (!done && n_run < 40) begin
      tick(1'b0, 1'b0, '0, 0);
      n_run++;
    end
    check_value("t1_run_len", n_run, 5);
    check_value("t1_cycles", cycle_count, 32'd5);
    check_value("t1_tcount", trace_count, 5'd1);
    tick(1'b0, 1'b0, '0, 0);
    check_value("t1_entry0", rd_data, 32'd0);

    // 2: restart, then 1,2,3,3,3,3,3.
    seq2 = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
    tick(1'b0, 1'b1, '0, 0);
    hold_phase("t2_hold_len", '0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, seq2[i], 0);
      check_value("t2_done", done, (i == 6));
    end
    check_value("t2_cycles", cycle_count, 32'd7);
    check_value("t2_tcount", trace_count, 5'd3);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, i);
    check_value("t2_entry3", rd_data, 32'd0);

    // 3: 20 distinct values wrap the 16-entry trace; stable done lands on the cycle limit.
    tick(1'b0, 1'b1, '0, 0);
    hold_phase("t3_hold_len", '0);
    for (int v = 1; v <= 20; v++) tick(1'b0, 1'b0, 32'(v), 0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'd20, 0);
    check_value("t3_done", done, 1'b1);
    check_value("t3_timeout", timeout, 1'b0);
    check_value("t3_tcount", trace_count, 5'd16);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, '0, i);
      check_value("t3_entry", rd_data, 32'(i + 5));
    end
    rd_idx = 4'd0;
    #2;
    check_value("t3_read_lag", rd_data, 32'd20);
    tick(1'b0, 1'b0, '0, 0);
    check_value("t3_entry0", rd_data, 32'd5);

    // 4: reset six cycles into a run.
    tick(1'b0, 1'b1, '0, 0);
    hold_phase("t4_hold_len", '0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, $urandom(), 0);
    tick(1'b1, 1'b0, '0, 0);
    check_value("t4_cpu_reset", cpu_reset, 1'b1);
    check_value("t4_running", running, 1'b0);
    check_value("t4_tcount", trace_count, 5'd0);
    check_value("t4_cycles", cycle_count, 32'd0);
    hold_phase("t4_hold_len2", 32'd7);
    run_to_done("t4_done", 32'd7);

    // 5: restart from DONE with constant 7.
    tick(1'b0, 1'b1, 32'd7, 0);
    check_value("t5_cpu_reset", cpu_reset, 1'b1);
    hold_phase("t5_hold_len", 32'd7);
    run_to_done("t5_done", 32'd7);
    check_value("t5_tcount", trace_count, 5'd1);
    check_value("t5_timeout", timeout, 1'b0);
    tick(1'b0, 1'b0, '0, 0);
    check_value("t5_entry0", rd_data, 32'd7);

    // 6: incrementing values up to the cycle limit.
    tick(1'b0, 1'b1, '0, 0);
    hold_phase("t6_hold_len", '0);
    for (int i = 0; i < MC; i++) tick(1'b0, 1'b0, 32'(i + 100), 0);
    check_value("t6_cycles", cycle_count, 32'(MC));
    check_value("t6_done", done, TO_EN);
    check_value("t6_timeout", timeout, TO_EN);
    check_value("t6_running", running, !TO_EN);
    run_to_done("t6_end", 32'd999);

    // Randomized traffic: bursty values, stray restarts, occasional reset.
    r_val = '0;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_rs  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) r_val = 32'($urandom_range(0, 5));
      tick(r_rst, r_rs, r_val, $urandom_range(0, 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
